// File: rtl/arm_issue_stage.sv
// arm_issue_stage: decode-to-execute issue register with RAW hazard detection, flush and halt drain.
// Define ARM_ISSUE_FWD_EN to enable result forwarding and the CPSR bypass.
module arm_issue_stage #(
  parameter int NUM_RD  = 3,
  parameter int NUM_STG = 2,
  parameter int REG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 32
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [31:0]               in_inst,
  input  logic                      in_halt,
  input  logic [NUM_RD-1:0]         rd_mask,
  input  logic [NUM_RD*REG_W-1:0]   rd_num,
  input  logic [NUM_RD*DATA_W-1:0]  rd_data,
  input  logic [31:0]               cpsr_in,
  input  logic                      ex_cpsr_we,
  input  logic [31:0]               ex_cpsr,
  input  logic [NUM_STG-1:0]        stg_we,
  input  logic [NUM_STG*REG_W-1:0]  stg_num,
  input  logic [NUM_STG*DATA_W-1:0] stg_data,
  input  logic [NUM_STG-1:0]        stg_ok,
  input  logic                      pipe_empty,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [31:0]               out_inst,
  output logic [NUM_RD*DATA_W-1:0]  out_opnd,
  output logic [31:0]               out_cpsr,
  output logic                      halted,
  output logic [31:0]               stall_cycles
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t r_state, w_state_nxt;
  logic r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0] r_inst, r_cpsr, r_stall, w_cpsr;
  logic [NUM_RD*DATA_W-1:0] r_opnd, w_opnd;
  logic [NUM_RD-1:0] w_hit, w_ok;
  logic w_hazard, w_advance, w_load;
  // Stages scanned oldest to youngest so the youngest matching writer wins.
  always_comb begin
    w_opnd = rd_data;
    w_hit = '0;
    w_ok = '1;
    for (int k = 0; k < NUM_RD; k++)
      for (int s = NUM_STG - 1; s >= 0; s--)
        if (rd_mask[k] && stg_we[s] && rd_num[k*REG_W +: REG_W] == stg_num[s*REG_W +: REG_W]) begin
          w_hit[k] = 1'b1;
          w_ok[k] = stg_ok[s];
`ifdef ARM_ISSUE_FWD_EN
          w_opnd[k*DATA_W +: DATA_W] = stg_data[s*DATA_W +: DATA_W];
`endif
        end
  end
`ifdef ARM_ISSUE_FWD_EN
  assign w_hazard = |(w_hit & ~w_ok);
  assign w_cpsr = ex_cpsr_we ? ex_cpsr : cpsr_in;
`else
  logic w_unused;
  assign w_unused = ^{stg_ok, stg_data, ex_cpsr, w_ok};
  assign w_hazard = |w_hit || (ex_cpsr_we && in_ctrl[0]);
  assign w_cpsr = cpsr_in;
`endif
  assign w_advance = !r_valid || out_ready;
  assign in_ready = w_advance && !w_hazard && !flush && r_state == RUN;
  assign w_load = in_ready && in_valid && !in_halt;
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     w_state_nxt = (in_valid && in_ready && in_halt) ? DRAIN : RUN;
      DRAIN:   w_state_nxt = flush ? RUN : pipe_empty ? HALTED : DRAIN;
      default: w_state_nxt = HALTED;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_inst  <= '0;
      r_opnd  <= '0;
      r_cpsr  <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) r_valid <= 1'b0;
      else if (w_advance) r_valid <= w_load;
      if (w_load) begin
        r_ctrl <= in_ctrl;
        r_inst <= in_inst;
        r_opnd <= w_opnd;
        r_cpsr <= w_cpsr;
      end
      if (in_valid && w_hazard && r_state == RUN && !flush && r_stall != '1) r_stall <= r_stall + 32'd1;
    end
  end
  assign out_valid    = r_valid;
  assign out_ctrl     = r_ctrl;
  assign out_inst     = r_inst;
  assign out_opnd     = r_opnd;
  assign out_cpsr     = r_cpsr;
  assign halted       = r_state == HALTED;
  assign stall_cycles = r_stall;
endmodule

// File: tb/tb_arm_issue_stage.sv
// tb_arm_issue_stage: randomized scoreboard bench for arm_issue_stage against a behavioural model.
module tb_arm_issue_stage;
  localparam int NR = 3, NS = 2, RW = 4, DW = 32, CW = 32;
  logic clk = 1'b0, rst;
  logic in_valid, in_ready, in_halt, ex_cpsr_we, pipe_empty, flush, out_valid, out_ready, halted;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [31:0] in_inst, cpsr_in, ex_cpsr, out_inst, out_cpsr, stall_cycles;
  logic [NR-1:0] rd_mask;
  logic [NR*RW-1:0] rd_num;
  logic [NR*DW-1:0] rd_data, out_opnd;
  logic [NS-1:0] stg_we, stg_ok;
  logic [NS*RW-1:0] stg_num;
  logic [NS*DW-1:0] stg_data;

  arm_issue_stage #(.NUM_RD(NR), .NUM_STG(NS), .REG_W(RW), .DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_inst(in_inst), .in_halt(in_halt), .rd_mask(rd_mask), .rd_num(rd_num), .rd_data(rd_data),
    .cpsr_in(cpsr_in), .ex_cpsr_we(ex_cpsr_we), .ex_cpsr(ex_cpsr), .stg_we(stg_we),
    .stg_num(stg_num), .stg_data(stg_data), .stg_ok(stg_ok), .pipe_empty(pipe_empty),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_inst(out_inst), .out_opnd(out_opnd), .out_cpsr(out_cpsr), .halted(halted),
    .stall_cycles(stall_cycles));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [191:0] q[$];
  bit m_valid = 0;
  int m_state = 0;
  logic [31:0] m_stall = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: for each read port find the youngest writing stage, then decide hazard/operand.
  function automatic void resolve(output bit hz, output logic [NR*DW-1:0] op, output logic [31:0] cp);
    hz = 0;
    op = rd_data;
    cp = cpsr_in;
    for (int k = 0; k < NR; k++) begin
      int w = -1;
      for (int s = 0; s < NS; s++)
        if (w < 0 && rd_mask[k] && stg_we[s] && rd_num[k*RW +: RW] == stg_num[s*RW +: RW]) w = s;
      if (w >= 0) begin
`ifdef ARM_ISSUE_FWD_EN
        if (!stg_ok[w]) hz = 1;
        op[k*DW +: DW] = stg_data[w*DW +: DW];
`else
        hz = 1;
`endif
      end
    end
`ifdef ARM_ISSUE_FWD_EN
    if (ex_cpsr_we) cp = ex_cpsr;
`else
    if (ex_cpsr_we && in_ctrl[0]) hz = 1;
`endif
  endfunction

  function automatic bit model_rdy(input bit hz);
    return (!m_valid || out_ready) && !hz && !flush && m_state == 0;
  endfunction

  // Predictor: advances the model and pushes each accepted instruction's expected output.
  always @(posedge clk or posedge rst) begin
    bit hz, rdy;
    logic [NR*DW-1:0] op;
    logic [31:0] cp;
    if (rst) begin
      m_valid = 0;
      m_state = 0;
      m_stall = 0;
      q.delete();
    end else begin
      resolve(hz, op, cp);
      rdy = model_rdy(hz);
      if (in_valid && hz && m_state == 0 && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (rdy && in_valid && !in_halt) q.push_back({in_ctrl, in_inst, op, cp});
      if (flush) m_valid = 0;
      else if (!m_valid || out_ready) m_valid = rdy && in_valid && !in_halt;
      if (m_state == 0 && rdy && in_valid && in_halt) m_state = 1;
      else if (m_state == 1) m_state = flush ? 0 : (pipe_empty ? 2 : 1);
    end
  end

  // Monitor: checks the DUT mid-cycle and retires outputs that leave the register.
  always @(negedge clk) begin
    bit hz;
    logic [NR*DW-1:0] op;
    logic [31:0] cp;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_payload", {out_ctrl, out_inst, out_opnd, out_cpsr}, 0);
    end else begin
      resolve(hz, op, cp);
      chk("in_ready", in_ready, model_rdy(hz));
      chk("out_valid", out_valid, m_valid);
      chk("halted", halted, m_state == 2);
      chk("stall_cycles", stall_cycles, m_stall);
      if (out_valid) begin
        if (q.size() == 0) chk("scoreboard_empty", 1, 0);
        else begin
          chk("payload", {out_ctrl, out_inst, out_opnd, out_cpsr}, q[0]);
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input int mode);
    in_valid   = $urandom % 4 != 0;
    in_ctrl    = $urandom;
    in_inst    = $urandom;
    in_halt    = $urandom % 60 == 0;
    rd_mask    = NR'($urandom);
    for (int k = 0; k < NR; k++) rd_num[k*RW +: RW] = RW'($urandom % 4);
    for (int k = 0; k < NR; k++) rd_data[k*DW +: DW] = $urandom;
    cpsr_in    = $urandom;
    ex_cpsr    = $urandom;
    ex_cpsr_we = mode != 0 && $urandom % 3 == 0;
    for (int s = 0; s < NS; s++) begin
      stg_num[s*RW +: RW] = RW'($urandom % 4);
      stg_data[s*DW +: DW] = $urandom;
    end
    stg_we     = mode == 0 ? '0 : NS'($urandom);
    stg_ok     = mode == 1 ? NS'($urandom | $urandom) : NS'($urandom);
    pipe_empty = $urandom % 3 == 0;
    flush      = $urandom % 16 == 0;
    out_ready  = mode == 0 ? 1'b1 : $urandom % 4 != 0;
  endtask

  initial begin
    int halt_wait = 0;
    rst = 1'b1;
    drive(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      halt_wait = m_state == 2 ? halt_wait + 1 : 0;
      rst = halt_wait > 4 || $urandom % 700 == 0;
      drive((i / 250) % 3);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arm_issue_stage.md
# arm_issue_stage

Parametrised decode-to-execute issue register for the ARM pipeline. Takes decoded control bundles and register-file read data, detects RAW hazards against any number of downstream stages, forwards ready results into operands, and stalls on not-yet-available results. Also handles the CPSR bypass, flush, halt drain and a stall-cycle counter. Sits between the IF/ID register and the EX stage; uses valid/ready handshakes on both sides.

## Interface
- NUM_RD, default 3: register read ports per instruction.
- NUM_STG, default 2: downstream stages checked for hazards; index 0 is the youngest (EX).
- REG_W, default 4: register number width.
- DATA_W, default 32: data width.
- CTRL_W, default 32: opaque decoded control bundle width.

- clk  in  1  clock; every flop updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle.
- in_ctrl  in  CTRL_W  decoded control bundle.
- in_inst  in  32  raw instruction word.
- in_halt  in  1  decoded instruction is a halt.
- rd_mask  in  NUM_RD  port k is a real read.
- rd_num  in  NUM_RD*REG_W  register numbers to read.
- rd_data  in  NUM_RD*DATA_W  register-file read data.
- cpsr_in  in  32  architectural CPSR.
- ex_cpsr_we, ex_cpsr  in  1, 32  CPSR being written in EX.
- stg_we  in  NUM_STG  stage s writes a register.
- stg_num  in  NUM_STG*REG_W  destination register of stage s.
- stg_data  in  NUM_STG*DATA_W  result of stage s.
- stg_ok  in  NUM_STG  stg_data of stage s is final (0 = load still in flight).
- pipe_empty  in  1  no valid instruction downstream.
- flush  in  1  kill the held and incoming instruction.
- out_valid, out_ready  out/in  1  downstream handshake.
- out_ctrl, out_inst  out  CTRL_W, 32  registered copies.
- out_opnd  out  NUM_RD*DATA_W  resolved operands.
- out_cpsr  out  32  resolved CPSR.
- halted  out  1  sticky halt indication.
- stall_cycles  out  32  hazard stall counter.

## Operation
- Match: port k matches stage s when rd_mask[k], stg_we[s] and rd_num[k]==stg_num[s].
- Priority: the lowest matching s wins (youngest writer).
- Hazard: some port k has a winning stage s with stg_ok[s]==0.
- Operand: the winning stage's stg_data; rd_data[k] when no stage matches. Unmasked ports pass rd_data.
- out_cpsr: ex_cpsr when ex_cpsr_we is set, else cpsr_in.
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !flush && state==RUN.
- On advance, the register loads when in_ready && in_valid && !in_halt; otherwise out_valid goes to 0 (bubble).
- If advance is 0 and flush is 0, all out_* hold.
- flush: out_valid goes to 0 next edge regardless of out_ready. flush wins over load.
- FSM states:
  - RUN: on in_valid && in_ready && in_halt, accept the halt (no issue) and go to DRAIN.
  - DRAIN: in_ready=0. Go to HALTED when pipe_empty. flush returns the FSM to RUN.
  - HALTED: halted=1, in_ready=0. Exits only via rst.
- stall_cycles increments on each cycle with in_valid && hazard && state==RUN && !flush. It saturates at 0xFFFFFFFF.

## Timing
- Reset values: out_valid=0, halted=0, stall_cycles=0, state RUN. out_ctrl, out_inst, out_opnd and out_cpsr reset to 0.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle with no hazards and out_ready held high.
- A load followed by a dependent instruction stalls while stg_ok for that stage is 0. It issues in the cycle stg_ok rises; the stalled cycle emits a bubble.
- halted rises the edge after pipe_empty is sampled high in DRAIN, at the earliest two cycles after the halt is accepted.
- Reset asserted mid-operation clears everything asynchronously. No partial issue follows reset release.

## Configuration
- ARM_ISSUE_FWD_EN defined: forwarding as described above.
- ARM_ISSUE_FWD_EN undefined: any match is a hazard regardless of stg_ok. out_opnd is always rd_data, with no bypass muxes. ex_cpsr_we also counts as a hazard when the in_ctrl CPSR-read bit (bit 0) is set, and out_cpsr is then always cpsr_in.

## Test plan
- Forward, FWD_EN: stage0 writes R3=0x11 (stg_ok=1), stage1 writes R3=0x22. Issue with rd_num[0]=3 -> out_opnd[0]=0x11, no stall, stall_cycles=0.
- Load-use: stage0 writes R5 with stg_ok=0 for 2 cycles, then 1 with data 0xABCD. Issue reading R5 -> in_ready low 2 cycles, stall_cycles=2, then out_opnd=0xABCD.
- Backpressure: out_ready=0 for 3 cycles with valid output held -> out_* stable, in_ready=0. Release -> the next instruction issues next edge.
- Flush during stall: hazard active, then flush=1 for one cycle -> out_valid=0 next edge, and stall_cycles does not increment that cycle.
- Halt: accept halt with pipe_empty=0 for 3 cycles, then 1 -> in_ready=0 throughout, halted=1 one edge later, stays 1. Assert rst -> halted=0 immediately.
- No FWD_EN: same stimulus as the forward test -> stall until stage0 and stage1 stg_we clear, then out_opnd[0]=rd_data[0].
